feature_map_buffer: RTL and testbench

- Sink for a convolutional layer's valid-qualified output stream: captures one full output feature map (OUT_SIZE x OUT_SIZE pixels, Q_CHANNELS words per pixel) into on-chip RAM in raster order.
- Optional ReLU is applied on write.
- Once the map is complete, a downstream stage (next layer feeder, host readout) drains it in raster order with a 1-cycle-latency read port.
- Sits directly after a convolutional layer; its capture side obeys the same clk_en/valid qualification.

---
 rtl/feature_map_buffer_pkg.sv | 44 ++++
 rtl/feature_map_buffer_if.sv | 39 +++
 rtl/feature_map_buffer_ram.sv | 48 ++++
 rtl/feature_map_buffer.sv | 126 ++++++++++++
 tb/tb_feature_map_buffer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/feature_map_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fm_pkg
//  Description : Shared types and helpers for the feature map buffer:
//                capture/drain state encoding, depth and address-width
//                helpers, and the per-word ReLU clamp.
//  Revision    : 1.0  initial release
// ============================================================================
package fm_pkg;

    // Widest channel word the ReLU helper handles.
    localparam int c_MAX_WORD_W = 64;

    // Single buffer: the map is either being captured or being drained.
    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } fm_state_t;

    // Number of pixels in one OUT_SIZE x OUT_SIZE map.
    function automatic int fm_depth(input int out_size);
        return out_size * out_size;
    endfunction

    // Pointer width; a one-entry map still needs a 1-bit address.
    function automatic int fm_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Clamp a negative two's-complement word of the given width to zero.
    // The word arrives zero-extended; only bit [width-1] is the sign.
    function automatic logic [c_MAX_WORD_W-1:0] relu_word(
        input logic [c_MAX_WORD_W-1:0] word,
        input int                      width,
        input bit                      enable
    );
        if (enable && word[width-1]) begin
            return '0;
        end
        return word;
    endfunction

endpackage : fm_pkg
`default_nettype wire

// File: rtl/feature_map_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : feature_map_buffer_if
//  Description : Capture stream and drain port of the feature map buffer.
//                master : conv layer / downstream reader side
//                slave  : the buffer itself
//  Signals     : clk_en, in_data, in_valid  -> capture stream
//                rd_en                      -> drain request
//                frame_ready, rd_data, rd_valid, rd_last, overflow <- status
//  Revision    : 1.0  initial release
// ============================================================================
interface feature_map_buffer_if #(
    parameter int Q_WIDTH    = 16,
    parameter int Q_CHANNELS = 4
);
    localparam int c_PIX_W = Q_WIDTH * Q_CHANNELS;

    logic               clk_en;
    logic [c_PIX_W-1:0] in_data;
    logic               in_valid;
    logic               frame_ready;
    logic               rd_en;
    logic [c_PIX_W-1:0] rd_data;
    logic               rd_valid;
    logic               rd_last;
    logic               overflow;

    modport master (
        output clk_en, in_data, in_valid, rd_en,
        input  frame_ready, rd_data, rd_valid, rd_last, overflow
    );

    modport slave (
        input  clk_en, in_data, in_valid, rd_en,
        output frame_ready, rd_data, rd_valid, rd_last, overflow
    );

endinterface : feature_map_buffer_if
`default_nettype wire

// File: rtl/feature_map_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fm_ram
//  Description : Simple dual-port RAM, one write port and one registered
//                read port (1-cycle latency). The read register only loads
//                on rd_en, so it holds its last value otherwise; rst clears
//                just that register, never the array.
//  Ports       : clk, rst                 clock / sync reset of read register
//                wr_en, wr_addr, wr_data  write port
//                rd_en, rd_addr, rd_data  registered read port
//  Revision    : 1.0  initial release
// ============================================================================
module fm_ram #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 36,
    parameter int ADDR_W = 6
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire logic [WIDTH-1:0]  wr_data,
    input  wire logic              rd_en,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output logic      [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : fm_ram
`default_nettype wire

// File: rtl/feature_map_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : feature_map_buffer
//  Description : Captures one OUT_SIZE x OUT_SIZE output feature map from a
//                conv layer (optional ReLU on write), then lets a downstream
//                stage drain it in raster order through a 1-cycle read port.
//  Ports       : clk, rst  clock and synchronous active-high reset
//                bus       feature_map_buffer_if.slave (capture + drain)
//  Revision    : 1.0  initial release
// ============================================================================
module feature_map_buffer #(
    parameter int Q_WIDTH    = 16,
    parameter int Q_CHANNELS = 4,
    parameter int OUT_SIZE   = 6,
    parameter int RELU       = 0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    feature_map_buffer_if.slave bus
);

    import fm_pkg::*;

    localparam int c_PIX_W  = Q_WIDTH * Q_CHANNELS;
    localparam int c_DEPTH  = fm_depth(OUT_SIZE);
    localparam int c_ADDR_W = fm_addr_w(c_DEPTH);

    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(c_DEPTH - 1);
    localparam logic [c_ADDR_W-1:0] c_ADDR_ONE  = c_ADDR_W'(1);

    fm_state_t           r_state;
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic                r_rd_valid;
    logic                r_rd_last;
    logic                r_overflow;

    logic                w_in_fire;
    logic                w_accept;
    logic                w_drop;
    logic                w_rd_fire;
    logic [c_PIX_W-1:0]  w_wr_data;
    logic [c_PIX_W-1:0]  w_ram_rd_data;

    // A pixel offered while draining is dropped and flagged; this includes
    // the cycle of the final read, since the state only flips after it.
    assign w_in_fire = bus.clk_en & bus.in_valid;
    assign w_accept  = w_in_fire & (r_state == FILL);
    assign w_drop    = w_in_fire & (r_state == DRAIN);
    // Reads are not qualified by clk_en: the reader runs independently.
    assign w_rd_fire = bus.rd_en & (r_state == DRAIN);

    // Per-channel ReLU on the write path; no width change.
    for (genvar k = 0; k < Q_CHANNELS; k++) begin : g_relu
        logic [c_MAX_WORD_W-1:0] w_word_ext;
        assign w_word_ext = c_MAX_WORD_W'(bus.in_data[Q_WIDTH*k +: Q_WIDTH]);
        assign w_wr_data[Q_WIDTH*k +: Q_WIDTH] =
            Q_WIDTH'(relu_word(w_word_ext, Q_WIDTH, RELU != 0));
    end

    fm_ram #(
        .WIDTH  (c_PIX_W),
        .DEPTH  (c_DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_accept & ~rst),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_data),
        .rd_en   (w_rd_fire),
        .rd_addr (r_rd_ptr),
        .rd_data (w_ram_rd_data)
    );

    // Capture/drain FSM with pointers and registered read status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_last  <= w_rd_fire && (r_rd_ptr == c_LAST_ADDR);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (r_wr_ptr == c_LAST_ADDR) begin
                            r_state  <= DRAIN;
                            r_wr_ptr <= '0;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_ADDR_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (w_rd_fire) begin
                        if (r_rd_ptr == c_LAST_ADDR) begin
                            r_state  <= FILL;
                            r_rd_ptr <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + c_ADDR_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign bus.frame_ready = (r_state == DRAIN);
    assign bus.rd_data     = w_ram_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_last     = r_rd_last;
    assign bus.overflow    = r_overflow;

endmodule : feature_map_buffer
`default_nettype wire

// File: tb/tb_feature_map_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_feature_map_buffer
//  Description : Directed self-checking bench for feature_map_buffer with
//                Q_WIDTH=8, Q_CHANNELS=2, OUT_SIZE=2 (4 pixels). Two DUTs
//                share one stimulus stream: one with RELU=0, one with RELU=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_feature_map_buffer;

    localparam int Q_WIDTH    = 8;
    localparam int Q_CHANNELS = 2;
    localparam int OUT_SIZE   = 2;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    feature_map_buffer_if #(.Q_WIDTH(Q_WIDTH), .Q_CHANNELS(Q_CHANNELS)) bus_raw ();
    feature_map_buffer_if #(.Q_WIDTH(Q_WIDTH), .Q_CHANNELS(Q_CHANNELS)) bus_relu ();

    assign bus_relu.clk_en   = bus_raw.clk_en;
    assign bus_relu.in_data  = bus_raw.in_data;
    assign bus_relu.in_valid = bus_raw.in_valid;
    assign bus_relu.rd_en    = bus_raw.rd_en;

    feature_map_buffer #(
        .Q_WIDTH(Q_WIDTH), .Q_CHANNELS(Q_CHANNELS), .OUT_SIZE(OUT_SIZE), .RELU(0)
    ) u_dut_raw (
        .clk (clk),
        .rst (rst),
        .bus (bus_raw.slave)
    );

    feature_map_buffer #(
        .Q_WIDTH(Q_WIDTH), .Q_CHANNELS(Q_CHANNELS), .OUT_SIZE(OUT_SIZE), .RELU(1)
    ) u_dut_relu (
        .clk (clk),
        .rst (rst),
        .bus (bus_relu.slave)
    );

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] data);
        bus_raw.clk_en   = 1'b1;
        bus_raw.in_valid = 1'b1;
        bus_raw.in_data  = data;
        tick();
        bus_raw.in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp_raw,
                             input logic [15:0] exp_relu, input logic exp_last);
        bus_raw.rd_en = 1'b1;
        tick();
        bus_raw.rd_en = 1'b0;
        check_value({tag, " rd_valid"}, 32'(bus_raw.rd_valid), 32'd1);
        check_value({tag, " rd_data"},  32'(bus_raw.rd_data),  32'(exp_raw));
        check_value({tag, " rd_last"},  32'(bus_raw.rd_last),  32'(exp_last));
        check_value({tag, " relu rd_data"}, 32'(bus_relu.rd_data), 32'(exp_relu));
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, " frame_ready"}, 32'(bus_raw.frame_ready), 32'd0);
        check_value({tag, " rd_valid"},    32'(bus_raw.rd_valid),    32'd0);
        check_value({tag, " rd_last"},     32'(bus_raw.rd_last),     32'd0);
        check_value({tag, " overflow"},    32'(bus_raw.overflow),    32'd0);
        check_value({tag, " rd_data"},     32'(bus_raw.rd_data),     32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the test sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus_raw.clk_en   = 1'b0;
        bus_raw.in_valid = 1'b0;
        bus_raw.in_data  = '0;
        bus_raw.rd_en    = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // ---- basic fill and back-to-back drain, RELU=0 values ----
        push(16'h0102);
        check_value("t1 frame_ready after 1", 32'(bus_raw.frame_ready), 32'd0);
        push(16'h0304);
        push(16'h0506);
        check_value("t1 frame_ready after 3", 32'(bus_raw.frame_ready), 32'd0);
        push(16'h0708);
        check_value("t1 frame_ready after 4", 32'(bus_raw.frame_ready), 32'd1);
        pop_check("t1 px0", 16'h0102, 16'h0102, 1'b0);
        pop_check("t1 px1", 16'h0304, 16'h0304, 1'b0);
        pop_check("t1 px2", 16'h0506, 16'h0506, 1'b0);
        pop_check("t1 px3", 16'h0708, 16'h0708, 1'b1);
        check_value("t1 frame_ready after drain", 32'(bus_raw.frame_ready), 32'd0);
        tick();
        check_value("t1 idle rd_valid", 32'(bus_raw.rd_valid), 32'd0);
        check_value("t1 idle rd_last",  32'(bus_raw.rd_last),  32'd0);
        check_value("t1 rd_data hold",  32'(bus_raw.rd_data),  32'h0708);

        // ---- ReLU clamp on write ----
        push(16'hFF05);
        push(16'h80FF);
        push(16'h7F00);
        push(16'h0181);
        pop_check("t2 px0", 16'hFF05, 16'h0005, 1'b0);
        pop_check("t2 px1", 16'h80FF, 16'h0000, 1'b0);
        pop_check("t2 px2", 16'h7F00, 16'h7F00, 1'b0);
        pop_check("t2 px3", 16'h0181, 16'h0100, 1'b1);

        // ---- clk_en stalls with in_valid held high ----
        for (int p = 0; p < 4; p++) begin
            logic [15:0] stall_vals [4];
            stall_vals = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
            push(stall_vals[p]);
            if (p < 3) begin
                bus_raw.clk_en   = 1'b0;
                bus_raw.in_valid = 1'b1;
                bus_raw.in_data  = 16'h9999;
                for (int s = 0; s < 3; s++) tick();
                bus_raw.in_valid = 1'b0;
                check_value("t3 frame_ready during stall", 32'(bus_raw.frame_ready), 32'd0);
            end
        end
        check_value("t3 frame_ready", 32'(bus_raw.frame_ready), 32'd1);
        pop_check("t3 px0", 16'h0102, 16'h0102, 1'b0);
        pop_check("t3 px1", 16'h0304, 16'h0304, 1'b0);
        pop_check("t3 px2", 16'h0506, 16'h0506, 1'b0);
        pop_check("t3 px3", 16'h0708, 16'h0708, 1'b1);

        // ---- overflow while draining, including the final read cycle ----
        push(16'h1020);
        push(16'h3040);
        push(16'h5060);
        push(16'h7071);
        check_value("t4 overflow before", 32'(bus_raw.overflow), 32'd0);
        bus_raw.clk_en   = 1'b1;
        bus_raw.in_valid = 1'b1;
        bus_raw.in_data  = 16'hAAAA;
        pop_check("t4 px0", 16'h1020, 16'h1020, 1'b0);
        check_value("t4 overflow set", 32'(bus_raw.overflow), 32'd1);
        bus_raw.in_valid = 1'b0;
        pop_check("t4 px1", 16'h3040, 16'h3040, 1'b0);
        pop_check("t4 px2", 16'h5060, 16'h5060, 1'b0);
        bus_raw.in_valid = 1'b1;
        pop_check("t4 px3", 16'h7071, 16'h7071, 1'b1);
        bus_raw.in_valid = 1'b0;
        check_value("t4 frame_ready after drain", 32'(bus_raw.frame_ready), 32'd0);
        push(16'h0B0C);
        push(16'h0D0E);
        push(16'h1112);
        push(16'h1314);
        pop_check("t4 next px0", 16'h0B0C, 16'h0B0C, 1'b0);
        pop_check("t4 next px1", 16'h0D0E, 16'h0D0E, 1'b0);
        pop_check("t4 next px2", 16'h1112, 16'h1112, 1'b0);
        pop_check("t4 next px3", 16'h1314, 16'h1314, 1'b1);
        check_value("t4 overflow sticky", 32'(bus_raw.overflow), 32'd1);

        // ---- reset in the middle of a fill ----
        push(16'h5555);
        push(16'h6666);
        rst = 1'b1;
        tick();
        check_all_zero("t5 in reset");
        rst = 1'b0;
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        check_value("t5 frame_ready after 3", 32'(bus_raw.frame_ready), 32'd0);
        push(16'h4444);
        check_value("t5 frame_ready after 4", 32'(bus_raw.frame_ready), 32'd1);
        pop_check("t5 px0", 16'h1111, 16'h1111, 1'b0);
        pop_check("t5 px1", 16'h2222, 16'h2222, 1'b0);
        pop_check("t5 px2", 16'h3333, 16'h3333, 1'b0);
        pop_check("t5 px3", 16'h4444, 16'h4444, 1'b1);

        // ---- read gating: rd_en ignored in FILL, alternating reads in DRAIN ----
        bus_raw.rd_en = 1'b1;
        tick();
        check_value("t6 fill rd_valid empty", 32'(bus_raw.rd_valid), 32'd0);
        push(16'h2122);
        check_value("t6 fill rd_valid partial", 32'(bus_raw.rd_valid), 32'd0);
        push(16'h2324);
        bus_raw.rd_en = 1'b0;
        push(16'h2526);
        push(16'h2728);
        pop_check("t6 px0", 16'h2122, 16'h2122, 1'b0);
        tick();
        check_value("t6 gap0 rd_valid", 32'(bus_raw.rd_valid), 32'd0);
        check_value("t6 gap0 rd_data hold", 32'(bus_raw.rd_data), 32'h2122);
        pop_check("t6 px1", 16'h2324, 16'h2324, 1'b0);
        tick();
        check_value("t6 gap1 rd_valid", 32'(bus_raw.rd_valid), 32'd0);
        pop_check("t6 px2", 16'h2526, 16'h2526, 1'b0);
        tick();
        check_value("t6 gap2 rd_valid", 32'(bus_raw.rd_valid), 32'd0);
        pop_check("t6 px3", 16'h2728, 16'h2728, 1'b1);
        check_value("t6 frame_ready after drain", 32'(bus_raw.frame_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_feature_map_buffer
`default_nettype wire
